// File: rtl/lsu_pkg.sv
// lsu_pkg: shared opcodes, Funct3 codes, state encoding and fault codes for the load/store unit
package lsu_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        FAULT  = 2'd3
    } state_t;

    // Funct3 values that name a real access for the given kind
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        return is_store ? (f3 == F3_SB || f3 == F3_SH || f3 == F3_SW)
                        : (f3 == F3_LB || f3 == F3_LH || f3 == F3_LW ||
                           f3 == F3_LBU || f3 == F3_LHU);
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one (size lives in f3[1:0])
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        return (f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a != 2'd0);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane replication/strobes and load shift/extend
module lsu_align
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_is_store,
    input  logic [2:0]       i_f3,
    input  logic [1:0]       i_addr,
    input  logic [WIDTH-1:0] i_rs2,
    input  logic [WIDTH-1:0] i_rdata,
    output logic [WIDTH-1:0] o_wdata,
    output logic [3:0]       o_wstrb,
    output logic [WIDTH-1:0] o_ldata
);

    logic [1:0]       w_size;
    logic [WIDTH-1:0] w_shift;
    logic             w_signed;

    assign w_size   = i_f3[1:0];
    assign w_signed = ~i_f3[2];
    assign w_shift  = i_rdata >> {i_addr, 3'b000};

    // Replicate the store operand into every lane it may land in; loads drive nothing
    always_comb begin
        o_wdata = !i_is_store   ? '0 :
                  w_size == 2'd0 ? {4{i_rs2[7:0]}} :
                  w_size == 2'd1 ? {2{i_rs2[15:0]}} : i_rs2;
        o_wstrb = !i_is_store   ? 4'b0000 :
                  w_size == 2'd0 ? 4'b0001 << i_addr :
                  w_size == 2'd1 ? (i_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    end

    // Bring the addressed bytes down to bit 0 and extend by the Funct3 sign bit
    always_comb begin
        o_ldata = w_size == 2'd0 ? {{24{w_signed & w_shift[7]}}, w_shift[7:0]} :
                  w_size == 2'd1 ? {{16{w_signed & w_shift[15]}}, w_shift[15:0]} : w_shift;
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory stage with request/ready handshake, alignment, faults and timeout
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [6:0]       opcode,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] Mem_addr,
    input  logic [WIDTH-1:0] RS2,
    input  logic [4:0]       Rd_addr,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             busy,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic             st_done,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_addr, r_rs2, r_rdata, r_wb_data, w_ldata;
    logic [4:0]       r_rd, r_wb_rd;
    logic [2:0]       r_f3;
    logic             r_is_store, r_wb_valid, r_st_done;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_err_code, w_code;
    logic             w_accept, w_op_store, w_timeout;

    assign w_op_store = opcode == OP_STORE;
    assign w_accept   = r_state == IDLE && valid && (opcode == OP_LOAD || w_op_store);
    assign w_timeout  = r_cnt == CW'(TIMEOUT - 1);

    // Next state and the fault code to record when entering FAULT
    always_comb begin
        w_next = r_state;
        w_code = ERR_NONE;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (!f3_legal(w_op_store, Funct3)) begin
                        w_next = FAULT;
                        w_code = ERR_ILLEGAL;
                    end else if (misaligned(Funct3, Mem_addr[1:0])) begin
                        w_next = FAULT;
                        w_code = ERR_MISALIGN;
                    end else begin
                        w_next = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    w_next = RESP;
                end else if (w_timeout) begin
                    w_next = FAULT;
                    w_code = ERR_TIMEOUT;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Capture the instruction on accept so upstream may move on
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_f3       <= '0;
            r_is_store <= 1'b0;
        end else if (w_accept) begin
            r_addr     <= Mem_addr;
            r_rs2      <= RS2;
            r_rd       <= Rd_addr;
            r_f3       <= Funct3;
            r_is_store <= w_op_store;
        end
    end

    // Wait-cycle counter and read-word capture while the request is outstanding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            r_cnt <= (r_state == ACCESS) ? r_cnt + 1'b1 : '0;
            if (r_state == ACCESS && mem_ready) r_rdata <= mem_rdata;
        end
    end

    // Completion pulses, held load result and sticky fault code
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_st_done  <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_err_code <= ERR_NONE;
        end else begin
            r_wb_valid <= r_state == RESP && !r_is_store;
            r_st_done  <= r_state == RESP && r_is_store;
            if (r_state == RESP && !r_is_store) begin
                r_wb_rd   <= r_rd;
                r_wb_data <= w_ldata;
            end
            if (w_next == FAULT) r_err_code <= w_code;
        end
    end

    lsu_align #(.WIDTH(WIDTH)) u_align (
        .i_is_store(r_is_store),
        .i_f3      (r_f3),
        .i_addr    (r_addr[1:0]),
        .i_rs2     (r_rs2),
        .i_rdata   (r_rdata),
        .o_wdata   (mem_wdata),
        .o_wstrb   (mem_wstrb),
        .o_ldata   (w_ldata)
    );

    assign mem_req  = r_state == ACCESS;
    assign mem_we   = r_is_store;
    assign mem_addr = {r_addr[WIDTH-1:2], 2'b00};
    assign busy     = r_state != IDLE;
    assign err      = r_state == FAULT;
    assign err_code = r_err_code;
    assign wb_valid = r_wb_valid;
    assign wb_rd    = r_wb_rd;
    assign wb_data  = r_wb_data;
    assign st_done  = r_st_done;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of the load/store unit against a byte-level model
module tb_load_store_unit;

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;

    logic        clk = 1'b0, rst = 1'b1, valid = 1'b0, mem_ready = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  Funct3 = '0;
    logic [31:0] Mem_addr = '0, RS2 = '0, mem_rdata = '0;
    logic [4:0]  Rd_addr = '0;
    logic        mem_req, mem_we, busy, wb_valid, st_done, err;
    logic [31:0] mem_addr, mem_wdata, wb_data;
    logic [3:0]  mem_wstrb;
    logic [4:0]  wb_rd;
    logic [1:0]  err_code;

    int checks = 0, errors = 0;
    int req_n, busy_n, wbv_n, std_n, err_n, pulse_at;
    logic        stable, o_we;
    logic [31:0] o_addr, o_wdata, o_wbdata;
    logic [3:0]  o_wstrb;
    logic [4:0]  o_wbrd;
    logic [1:0]  o_code;

    load_store_unit #(.WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .valid(valid), .opcode(opcode), .Funct3(Funct3),
        .Mem_addr(Mem_addr), .RS2(RS2), .Rd_addr(Rd_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .st_done(st_done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Byte-level reference: fault code, store lanes/strobes and extended load value
    function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] rs2, input logic [31:0] rdata,
                                  output logic [1:0] code, output logic [3:0] strb,
                                  output logic [31:0] wd, output logic [31:0] ld);
        int sz, off;
        logic [31:0] mask;
        off = int'(addr[1:0]); code = 2'd0; strb = '0; wd = '0; ld = '0;
        if (st ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) begin code = 2'd2; return; end
        sz = 1 << f3[1:0];
        if (off % sz != 0) begin code = 2'd1; return; end
        if (st) begin
            strb = 4'((1 << sz) - 1) << off;
            for (int i = 0; i < 4; i++) wd[8*i +: 8] = rs2[8*(i % sz) +: 8];
        end else begin
            mask = 32'hFFFF_FFFF >> (32 - 8*sz);
            ld = (rdata >> (8*off)) & mask;
            if (!f3[2] && ld[8*sz-1]) ld = ld | ~mask;
        end
    endfunction

    // Present one instruction, answer mem_req after 'waits' stall cycles, record what the DUT did
    task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [31:0] rdata, input logic [4:0] rd,
                          input int waits);
        req_n = 0; busy_n = 0; wbv_n = 0; std_n = 0; err_n = 0; pulse_at = -1; stable = 1'b1;
        @(negedge clk);
        valid = 1'b1; opcode = op; Funct3 = f3; Mem_addr = addr; RS2 = rs2; Rd_addr = rd; mem_ready = 1'b0;
        @(posedge clk); #1;
        valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (mem_req) begin
                if (req_n == 0) begin
                    o_addr = mem_addr; o_wdata = mem_wdata; o_wstrb = mem_wstrb; o_we = mem_we;
                end else if ({o_addr, o_wdata, o_wstrb, o_we} !== {mem_addr, mem_wdata, mem_wstrb, mem_we}) begin
                    stable = 1'b0;
                end
                mem_ready = (req_n == waits);
                mem_rdata = mem_ready ? rdata : $urandom;
                req_n++;
            end else begin
                mem_ready = 1'b0;
            end
            if (busy) busy_n++;
            if (wb_valid) begin wbv_n++; pulse_at = c; o_wbdata = wb_data; o_wbrd = wb_rd; end
            if (st_done) begin std_n++; pulse_at = c; end
            if (err) begin err_n++; pulse_at = c; o_code = err_code; end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({mem_req, mem_we, busy, wb_valid, st_done, err, err_code, mem_wstrb, wb_rd} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got req=%b we=%b busy=%b wbv=%b std=%b err=%b code=%0d strb=%b rd=%0d, want all 0",
                     mem_req, mem_we, busy, wb_valid, st_done, err, err_code, mem_wstrb, wb_rd);
        end
        checks++;
        if ({mem_addr, mem_wdata, wb_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h wb_data=%h, want 0", mem_addr, mem_wdata, wb_data);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_store;
        logic [2:0]  f3[3]   = '{3'd2, 3'd0, 3'd1};
        logic [31:0] ad[3]   = '{32'h100, 32'h103, 32'h102};
        logic [31:0] rs[3]   = '{32'hDEADBEEF, 32'h000000A5, 32'h00001234};
        logic [3:0]  es[3]   = '{4'b1111, 4'b1000, 4'b1100};
        logic [31:0] ew[3]   = '{32'hDEADBEEF, 32'hA5A5A5A5, 32'h12341234};
        for (int i = 0; i < 3; i++) begin
            run_op(ST, f3[i], ad[i], rs[i], 32'h0, 5'd0, 0);
            checks++;
            if ({o_addr, o_wstrb, o_wdata, o_we} !== {ad[i] & ~32'h3, es[i], ew[i], 1'b1}) begin
                errors++;
                $display("FAIL store%0d_bus: got addr=%h strb=%b wdata=%h we=%b, want addr=%h strb=%b wdata=%h we=1",
                         i, o_addr, o_wstrb, o_wdata, o_we, ad[i] & ~32'h3, es[i], ew[i]);
            end
            checks++;
            if (pulse_at != 2 || std_n != 1 || busy_n != 2 || req_n != 1 || wbv_n != 0 || err_n != 0) begin
                errors++;
                $display("FAIL store%0d_timing: got pulse_at=%0d st_done=%0d busy=%0d req=%0d wbv=%0d err=%0d, want 2/1/2/1/0/0",
                         i, pulse_at, std_n, busy_n, req_n, wbv_n, err_n);
            end
        end
    endtask

    task automatic test_load;
        logic [2:0]  f3[5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
        logic [31:0] ad[5] = '{32'h3, 32'h3, 32'h2, 32'h0, 32'h0};
        int          wt[5] = '{0, 0, 0, 0, 3};
        logic [31:0] ev[5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
        for (int i = 0; i < 5; i++) begin
            run_op(LD, f3[i], ad[i], 32'hFFFF_FFFF, 32'h80FF7F01, 5'(i + 3), wt[i]);
            checks++;
            if (o_wbdata !== ev[i] || o_wbrd !== 5'(i + 3) || o_wstrb !== 4'b0 || o_we !== 1'b0 || o_wdata !== 32'h0) begin
                errors++;
                $display("FAIL load%0d_data: got wb_data=%h rd=%0d strb=%b we=%b wdata=%h, want %h rd=%0d strb=0 we=0 wdata=0",
                         i, o_wbdata, o_wbrd, o_wstrb, o_we, o_wdata, ev[i], i + 3);
            end
            checks++;
            if (pulse_at != 2 + wt[i] || wbv_n != 1 || busy_n != 2 + wt[i] || req_n != 1 + wt[i] || !stable) begin
                errors++;
                $display("FAIL load%0d_timing: got pulse_at=%0d wbv=%0d busy=%0d req=%0d stable=%b, want %0d/1/%0d/%0d/1",
                         i, pulse_at, wbv_n, busy_n, req_n, stable, 2 + wt[i], 2 + wt[i], 1 + wt[i]);
            end
        end
    endtask

    task automatic test_faults;
        logic [6:0]  op[3] = '{LD, LD, ST};
        logic [2:0]  f3[3] = '{3'd2, 3'd3, 3'd4};
        logic [31:0] ad[3] = '{32'h102, 32'h100, 32'h100};
        logic [1:0]  ec[3] = '{2'd1, 2'd2, 2'd2};
        for (int i = 0; i < 3; i++) begin
            run_op(op[i], f3[i], ad[i], 32'h55, 32'h0, 5'd1, 0);
            checks++;
            if (err_n != 1 || o_code !== ec[i] || req_n != 0 || busy_n != 1 || pulse_at != 0 || wbv_n + std_n != 0) begin
                errors++;
                $display("FAIL fault%0d: got err=%0d code=%0d req=%0d busy=%0d at=%0d done=%0d, want 1/%0d/0/1/0/0",
                         i, err_n, o_code, req_n, busy_n, pulse_at, wbv_n + std_n, ec[i]);
            end
            checks++;
            if (err_code !== ec[i]) begin
                errors++;
                $display("FAIL fault%0d_hold: got err_code=%0d, want %0d", i, err_code, ec[i]);
            end
        end
    endtask

    task automatic test_timeout;
        run_op(LD, 3'd2, 32'h200, 32'h0, 32'h0, 5'd2, 1000);
        checks++;
        if (req_n != 16 || err_n != 1 || o_code !== 2'd3 || pulse_at != 16 || busy_n != 17 || wbv_n != 0) begin
            errors++;
            $display("FAIL timeout: got req=%0d err=%0d code=%0d at=%0d busy=%0d wbv=%0d, want 16/1/3/16/17/0",
                     req_n, err_n, o_code, pulse_at, busy_n, wbv_n);
        end
    endtask

    task automatic test_ignored;
        run_op(7'b0110011, 3'd2, 32'h100, 32'h1, 32'h0, 5'd4, 0);
        checks++;
        if (req_n + busy_n + wbv_n + std_n + err_n != 0) begin
            errors++;
            $display("FAIL ignored_op: got req=%0d busy=%0d wbv=%0d std=%0d err=%0d, want all 0",
                     req_n, busy_n, wbv_n, std_n, err_n);
        end
    endtask

    task automatic test_back_to_back;
        int st_at = -1, ld_req_at = -1, wb_at = -1;
        logic [31:0] got = '0;
        @(negedge clk);
        valid = 1'b1; opcode = ST; Funct3 = 3'd2; Mem_addr = 32'h200; RS2 = 32'h0BADF00D;
        @(posedge clk); #1;
        opcode = LD; Funct3 = 3'd5; Mem_addr = 32'h2; Rd_addr = 5'd7;
        mem_ready = 1'b1; mem_rdata = 32'h13579BDF;
        for (int c = 0; c < 10; c++) begin
            if (st_done && !busy) st_at = c;
            if (mem_req && !mem_we && ld_req_at < 0) begin ld_req_at = c; valid = 1'b0; end
            if (wb_valid) begin wb_at = c; got = wb_data; end
            @(posedge clk); #1;
        end
        valid = 1'b0; mem_ready = 1'b0;
        checks++;
        if (st_at != 2 || ld_req_at != 3 || wb_at != 5 || got !== 32'h00001357) begin
            errors++;
            $display("FAIL back_to_back: got st_at=%0d ld_req_at=%0d wb_at=%0d data=%h, want 2/3/5/00001357",
                     st_at, ld_req_at, wb_at, got);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] w = $urandom;
        @(negedge clk);
        valid = 1'b1; opcode = LD; Funct3 = 3'd2; Mem_addr = 32'h40; mem_ready = 1'b0;
        @(posedge clk); #1;
        valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got mem_req=%b busy=%b, want 0/0", mem_req, busy);
        end
        @(negedge clk); rst = 1'b0;
        run_op(LD, 3'd2, 32'h44, 32'h0, w, 5'd9, 1);
        checks++;
        if (o_wbdata !== w || o_wbrd !== 5'd9 || pulse_at != 3 || o_addr !== 32'h44) begin
            errors++;
            $display("FAIL after_reset_lw: got data=%h rd=%0d at=%0d addr=%h, want %h/9/3/00000044",
                     o_wbdata, o_wbrd, pulse_at, o_addr, w);
        end
    endtask

    task automatic test_random;
        logic st;
        logic [2:0] f3;
        logic [31:0] addr, rs2, rdata, wd, ld;
        logic [4:0] rd;
        logic [1:0] code;
        logic [3:0] strb;
        int waits;
        for (int n = 0; n < 40; n++) begin
            st = 1'($urandom); f3 = 3'($urandom); addr = $urandom & 32'h0000_FFFF;
            rs2 = $urandom; rdata = $urandom; rd = 5'($urandom); waits = $urandom_range(0, 3);
            if (n % 4 != 0) f3 = st ? 3'($urandom_range(0, 2)) : (($urandom % 2) ? 3'd2 : 3'd4 + 3'($urandom % 2));
            model(st, f3, addr, rs2, rdata, code, strb, wd, ld);
            run_op(st ? ST : LD, f3, addr, rs2, rdata, rd, waits);
            checks++;
            if (code != 2'd0) begin
                if (err_n != 1 || o_code !== code || req_n != 0 || pulse_at != 0) begin
                    errors++;
                    $display("FAIL rand%0d_fault: got err=%0d code=%0d req=%0d at=%0d, want 1/%0d/0/0",
                             n, err_n, o_code, req_n, pulse_at, code);
                end
            end else if (o_addr !== (addr & ~32'h3) || o_we !== st || o_wstrb !== strb || o_wdata !== wd ||
                         !stable || req_n != waits + 1 || pulse_at != waits + 2 || err_n != 0 ||
                         (st ? std_n != 1 : (wbv_n != 1 || o_wbdata !== ld || o_wbrd !== rd))) begin
                errors++;
                $display("FAIL rand%0d_access: st=%b f3=%0d addr=%h got a=%h we=%b strb=%b wd=%h ld=%h rd=%0d req=%0d at=%0d, want a=%h strb=%b wd=%h ld=%h rd=%0d req=%0d at=%0d",
                         n, st, f3, addr, o_addr, o_we, o_wstrb, o_wdata, o_wbdata, o_wbrd, req_n, pulse_at,
                         addr & ~32'h3, strb, wd, ld, rd, waits + 1, waits + 2);
            end
        end
    endtask

    initial begin
        test_reset;
        test_store;
        test_load;
        test_faults;
        test_timeout;
        test_ignored;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage directly downstream of the ALU: consumes the computed memory address, store data and load/store opcode/Funct3.
- Runs a request/ready handshake to the data memory and aligns store bytes and strobes.
- Extracts and sign/zero-extends load data, and returns the result to writeback.
- Holds the pipeline (busy) while a transfer is outstanding; flags misaligned, illegal and timed-out accesses.

Parameters:
- WIDTH, 32, datapath and address width (only 32 is supported).
- TIMEOUT, 16, maximum cycles mem_req may wait for mem_ready before the access is aborted.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- valid  input  1  upstream instruction present this cycle
- opcode  input  7  instruction opcode
- Funct3  input  3  access size/sign selector
- Mem_addr  input  WIDTH  effective byte address from ALU
- RS2  input  WIDTH  store data
- Rd_addr  input  5  load destination register
- mem_req  output  1  memory request
- mem_we  output  1  1 = write
- mem_addr  output  WIDTH  word-aligned address: Mem_addr with bits [1:0] forced to 0
- mem_wdata  output  WIDTH  lane-aligned store data
- mem_wstrb  output  4  byte-lane write enables
- mem_ready  input  1  memory accepted/completed the request
- mem_rdata  input  WIDTH  read word, valid when mem_ready=1
- busy  output  1  stall upstream
- wb_valid  output  1  one-cycle load-result pulse
- wb_rd  output  5  load destination
- wb_data  output  WIDTH  extended load result
- st_done  output  1  one-cycle store-complete pulse
- err  output  1  one-cycle fault pulse
- err_code  output  2  1 misaligned, 2 illegal Funct3, 3 timeout

Behaviour:
- Reset:
  - Asynchronous, active-high.
  - Every output goes to 0 immediately; state goes to IDLE; the timeout counter clears.
  - A reset mid-access drops mem_req at once, and the access is lost.
- States:
  - IDLE -> ACCESS -> RESP -> IDLE.
  - Fault path: IDLE or ACCESS -> FAULT -> IDLE.
- busy = (state != IDLE).
- IDLE:
  - Accept only when valid=1 and opcode is 0000011 (load) or 0100011 (store). Other opcodes are ignored and produce no output.
  - On accept, latch the address, RS2, Rd_addr, Funct3 and the load/store kind.
- Legal Funct3:
  - Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - Stores: 0 SB, 1 SH, 2 SW.
  - Any other value -> FAULT, err_code=2.
- Alignment rules (checked at accept):
  - Halfword needs addr[0]=0.
  - Word needs addr[1:0]=0.
  - Violation -> FAULT, err_code=1, with no mem_req.
- ACCESS:
  - mem_req=1; mem_we, mem_addr, mem_wdata and mem_wstrb are registered and stable for the whole state.
  - Leave ACCESS on the first cycle mem_ready=1 is sampled; the load word is captured that cycle.
  - The counter increments each cycle in ACCESS. When it reaches TIMEOUT with no mem_ready, go to FAULT with err_code=3.
  - mem_req deasserts on leaving ACCESS.
- Store alignment:
  - SB: wdata = {4{RS2[7:0]}}, wstrb = 0001 << addr[1:0].
  - SH: wdata = {2{RS2[15:0]}}, wstrb = 0011 when addr[1]=0, else 1100.
  - SW: wdata = RS2, wstrb = 1111.
  - Loads drive wstrb=0000 and wdata=0.
- Load extraction:
  - Shift the read word right by 8*addr[1:0].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- RESP (one cycle):
  - Loads: wb_valid=1 with wb_rd/wb_data.
  - Stores: st_done=1.
  - Then return to IDLE. wb_data holds its value until the next load.
- FAULT (one cycle): err=1 with err_code, then IDLE. err_code holds until the next fault.
- Latency:
  - Accept at edge N, mem_req high after N.
  - With mem_ready=1 in the first ACCESS cycle, wb_valid/st_done is high for exactly one cycle after edge N+2. Total 3 cycles; each extra wait cycle adds 1.
  - A new accept is possible in the cycle busy returns to 0.
- valid while busy=1 is ignored; upstream must hold the instruction.
- Rd_addr=0 loads still pulse wb_valid; the register file discards the write.

Decomposition:
- Shared package lsu_pkg holds:
  - opcode constants LOAD=0000011 and STORE=0100011;
  - Funct3 constants LB/LH/LW/LBU/LHU/SB/SH/SW;
  - the state encoding IDLE/ACCESS/RESP/FAULT;
  - the err_code values.
- One combinational sub-module, lsu_align: store lane replication/strobe generation and load shift/extend.
- The FSM, timeout counter and registers live in load_store_unit.

Test Plan:
- SW addr 0x100, RS2 0xDEADBEEF, mem_ready on first ACCESS cycle -> mem_addr 0x100, wstrb 1111, wdata 0xDEADBEEF, st_done one cycle after edge N+2, busy high for 2 cycles.
- SB addr 0x103, RS2 0x000000A5 -> wstrb 1000, wdata 0xA5A5A5A5; SH addr 0x102, RS2 0x1234 -> wstrb 1100, wdata 0x12341234.
- mem_rdata 0x80FF7F01:
  - LB addr 0x3 -> wb_data 0xFFFFFF80.
  - LBU addr 0x3 -> 0x00000080.
  - LH addr 0x2 -> 0xFFFF80FF.
  - LHU addr 0x0 -> 0x00007F01.
  - LW addr 0x0 with 3 wait cycles -> 0x80FF7F01, wb_valid one cycle after edge N+5.
- LW addr 0x102 -> err=1, err_code=1, no mem_req ever; load Funct3=3 -> err_code=2.
- mem_ready held 0 -> mem_req for exactly TIMEOUT=16 cycles, then err_code=3 and busy clears.
- rst pulsed mid-ACCESS -> mem_req/busy drop asynchronously; after release, a fresh LW completes normally.
